rr_arbiter_fsm: RTL and testbench

//  - Round-robin, grant-holding arbiter that shares one resource between N requesters.
//  - Companion to priority_arbiter: same req/grnt one-hot contract, but fair rather than fixed-priority.
//  - A grant is held until the owner drops its request; the next owner is chosen by rotating priority.
//  - Sits between requester blocks and the shared datapath; grnt is registered, so it drives enables directly.

---
 rtl/rr_arb_pkg.sv | 30 +++
 rtl/rr_arbiter_fsm_if.sv | 22 ++
 rtl/rr_pick.sv | 46 ++++
 rtl/rr_arbiter_fsm.sv | 123 ++++++++++++
 tb/tb_rr_arbiter_fsm.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared types and helpers for the round-robin arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  localparam int ARB_N_MAX = 16;
  localparam int ARB_IDX_W = $clog2(ARB_N_MAX);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index of the set bit; the input is expected to be one-hot or zero.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_N_MAX-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N_MAX; i++) begin
      if (oh[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_fsm_if.sv
// ============================================================================
// Module      : rr_arbiter_fsm_if
// Description : Request/grant bundle between requesters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_fsm_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grnt;
  logic [IW-1:0] grnt_id;
  logic          busy;

  modport master (output req, input grnt, input grnt_id, input busy);
  modport slave  (input req, output grnt, output grnt_id, output busy);
endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_id,
  output logic          any
);

  logic [N-1:0]  w_cand;
  logic [IW-1:0] w_idx;
  logic          w_found;

  assign w_cand = req & ~mask;
  assign any    = |w_cand;

  always_comb begin
    win     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(ptr) + k) % N);
      if (!w_found && w_cand[w_idx]) begin
        win[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign win_id = IW'(onehot_to_idx(ARB_N_MAX'(win)));

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_fsm.sv
// ============================================================================
// Module      : rr_arbiter_fsm
// Description : Grant-holding round-robin arbiter with registered grant.
//               Optional hold limit enabled by define ARB_HOLD_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_fsm
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_fsm_if.slave bus
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > ARB_N_MAX || MAX_HOLD < 1) begin : g_bad_params
    $error("rr_arbiter_fsm: parameter out of range");
  end

  arb_state_t    r_state;
  logic [N-1:0]  r_grnt;
  logic [IW-1:0] r_grnt_id;
  logic [IW-1:0] r_ptr;
  logic          r_busy;

  logic          w_owner_req;
  logic [IW-1:0] w_next_ptr;
  logic [IW-1:0] w_pick_ptr;
  logic [N-1:0]  w_mask;
  logic [N-1:0]  w_win;
  logic [IW-1:0] w_win_id;
  logic          w_any;

  assign w_owner_req = |(bus.req & r_grnt);
  assign w_next_ptr  = (r_grnt_id == IW'(N - 1)) ? '0 : r_grnt_id + 1'b1;
  // While granted, every pick is a hand-over: start after the owner, never re-pick it.
  assign w_pick_ptr  = (r_state == GRANT) ? w_next_ptr : r_ptr;
  assign w_mask      = (r_state == GRANT) ? r_grnt : '0;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (w_pick_ptr),
    .mask   (w_mask),
    .win    (w_win),
    .win_id (w_win_id),
    .any    (w_any)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] r_hold_cnt;
  logic          w_preempt;
  assign w_preempt = (r_hold_cnt == HW'(MAX_HOLD - 1)) && w_any;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grnt    <= '0;
      r_grnt_id <= '0;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= GRANT;
            r_grnt    <= w_win;
            r_grnt_id <= w_win_id;
            r_busy    <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (!w_owner_req) begin
            r_ptr <= w_next_ptr;
            if (w_any) begin
              r_grnt    <= w_win;
              r_grnt_id <= w_win_id;
            end else begin
              r_state   <= IDLE;
              r_grnt    <= '0;
              r_grnt_id <= '0;
              r_busy    <= 1'b0;
            end
`ifdef ARB_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
          end
`ifdef ARB_HOLD_LIMIT_EN
          else if (w_preempt) begin
            r_ptr      <= w_next_ptr;
            r_grnt     <= w_win;
            r_grnt_id  <= w_win_id;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt != HW'(MAX_HOLD)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grnt    = r_grnt;
  assign bus.grnt_id = r_grnt_id;
  assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_fsm.sv
// ============================================================================
// Module      : tb_rr_arbiter_fsm
// Description : Self-checking bench for rr_arbiter_fsm (reference model + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_fsm;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [3:0] grnt;
    logic [1:0] id;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst_n;

  rr_arbiter_fsm_if #(.N(N)) bus ();

  rr_arbiter_fsm #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  // Reference model state
  int m_own  = 0;
  bit m_busy = 1'b0;
  int m_ptr  = 0;
  int m_hold = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = 0;
    m_busy = 1'b0;
    m_ptr  = 0;
    m_hold = 0;
  endtask

  task automatic model_pick(input logic [3:0] r, input int excl);
    m_busy = 1'b0;
    m_own  = 0;
    m_hold = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!m_busy && r[i] && i != excl) begin
        m_busy = 1'b1;
        m_own  = i;
      end
    end
  endtask

  task automatic model_clock(input logic [3:0] r);
    exp_t e;
    if (!m_busy) begin
      model_pick(r, -1);
    end else if (!r[m_own]) begin
      m_ptr = (m_own + 1) % N;
      model_pick(r, m_own);
    end else begin
`ifdef ARB_HOLD_LIMIT_EN
      if (m_hold == MAX_HOLD - 1 && (r & ~(4'b0001 << m_own)) != 4'b0000) begin
        m_ptr = (m_own + 1) % N;
        model_pick(r, m_own);
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
`endif
    end
    e.grnt = m_busy ? (4'b0001 << m_own) : 4'b0000;
    e.id   = m_busy ? 2'(m_own) : 2'b00;
    e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of requests, queue the expectation, compare after the edge.
  task automatic step(input logic [3:0] r);
    exp_t e;
    bus.req = r;
    model_clock(r);
    @(posedge clk);
    #1;
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_grnt", bus.grnt, e.grnt);
      check("sb_id", bus.grnt_id, e.id);
      check("sb_busy", bus.busy, e.busy);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_grnt", bus.grnt, 4'b0000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_id", bus.grnt_id, 2'b00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("onehot0", $onehot0(bus.grnt), 1'b1);
      check("busy_vs_grnt", bus.busy, |bus.grnt);
    end
  end

  initial begin
    logic [3:0] r;
    logic [3:0] exp_g;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("init_grnt", bus.grnt, 4'b0000);
    check("init_busy", bus.busy, 1'b0);
    check("init_id", bus.grnt_id, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-grant, then fairness restarts at requester 0
    step(4'b1111);
    step(4'b1110);
    check("pre_rst_grnt", bus.grnt, 4'b0010);
    bus.req = 4'b1111;
    async_reset();
    step(4'b1111);
    check("post_rst_grnt", bus.grnt, 4'b0001);

    // Rotation with no idle bubble
    step(4'b1110); check("rot1", bus.grnt, 4'b0010);
    step(4'b1101); check("rot2", bus.grnt, 4'b0100);
    step(4'b1011); check("rot3", bus.grnt, 4'b1000);
    step(4'b0111); check("rot4", bus.grnt, 4'b0001);

    // Same-edge release/request and pointer wrap
    step(4'b0110); check("se_own1", bus.grnt, 4'b0010);
    step(4'b0100); check("se_own2", bus.grnt, 4'b0100);
    step(4'b1000); check("se_own3", bus.grnt, 4'b1000);
    step(4'b0011); check("wrap", bus.grnt, 4'b0001);

    // Single requester, hold, release to idle
    step(4'b0000); check("idle_grnt", bus.grnt, 4'b0000);
    step(4'b0100); check("single_grnt", bus.grnt, 4'b0100);
    check("single_id", bus.grnt_id, 2'd2);
    repeat (3) step(4'b0100);
    check("single_held", bus.grnt, 4'b0100);
    step(4'b0000); check("single_rel", bus.grnt, 4'b0000);
    check("single_rel_busy", bus.busy, 1'b0);

    // Constant 0011: hold limit alternates owners, otherwise owner 0 keeps it
    async_reset();
    for (int s = 1; s <= 20; s++) begin
      step(4'b0011);
`ifdef ARB_HOLD_LIMIT_EN
      exp_g = (((s - 1) / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      check("hold", bus.grnt, exp_g);
    end

    // Random traffic against the model
    r = 4'b0000;
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
